// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
// Scoreboard entry layout and the register match helper.
package pipe_ctrl_pkg;

  localparam int RF_AW  = 5;
  localparam int FWD_RF = 0;

  typedef struct packed {
    logic             valid;
    logic [RF_AW-1:0] rd;
    logic             regwrite;
    logic             memread;
  } sb_entry_t;

  function automatic logic rd_match(
    input sb_entry_t        e,
    input logic [RF_AW-1:0] rs,
    input logic             used
  );
    return e.valid & e.regwrite & (e.rd != '0)
         & (e.rd == rs) & used;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// One source register checked against the whole scoreboard.
// Yields a load interlock hit and the issue-time forward select.
module hazard_match
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGES     = 3,
  parameter int LOAD_STAGES = 1,
  parameter int FWD_W       = 2
) (
  input  sb_entry_t [NSTAGES-1:0] sb,
  input  logic [RF_AW-1:0]        rs,
  input  logic                    used,
  output logic                    load_hit,
  output logic [FWD_W-1:0]        fwd_sel
);

  // scan oldest to youngest so the youngest qualifying stage wins
  always_comb begin
    load_hit = 1'b0;
    fwd_sel  = FWD_W'(FWD_RF);
    for (int j = NSTAGES - 2; j >= 0; j--) begin
      if (rd_match(sb[j], rs, used) &&
          !(sb[j].memread && (j + 1) < LOAD_STAGES))
        fwd_sel = FWD_W'(j + 1);
    end
    for (int j = 0; j < NSTAGES; j++) begin
      if (j < LOAD_STAGES && sb[j].memread &&
          rd_match(sb[j], rs, used))
        load_hit = 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard-based stall/flush/bubble and forwarding control.
// Tracks NSTAGES stages behind decode (stage 0 = EX).
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int RF_ADDRESS  = 5,
  parameter int NSTAGES     = 3,
  parameter int LOAD_STAGES = 1,
  parameter int FWD_W       = $clog2(NSTAGES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [RF_ADDRESS-1:0] id_rs1,
  input  logic [RF_ADDRESS-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [RF_ADDRESS-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  ex_redirect,
  input  logic                  ex_busy,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  flush_if_id,
  output logic                  bubble_ex,
  output logic [FWD_W-1:0]      fwd_a_sel,
  output logic [FWD_W-1:0]      fwd_b_sel,
  output logic [NSTAGES-1:0]    stage_valid
);

  sb_entry_t [NSTAGES-1:0] sb_q;
  sb_entry_t               id_e;
  logic                    a_load;
  logic                    b_load;
  logic [FWD_W-1:0]        a_sel;
  logic [FWD_W-1:0]        b_sel;
  logic                    load_use;
  logic                    redir;
  logic                    issue;

  hazard_match #(
    .NSTAGES     (NSTAGES),
    .LOAD_STAGES (LOAD_STAGES),
    .FWD_W       (FWD_W)
  ) u_match_a (
    .sb       (sb_q),
    .rs       (id_rs1),
    .used     (id_rs1_used),
    .load_hit (a_load),
    .fwd_sel  (a_sel)
  );

  hazard_match #(
    .NSTAGES     (NSTAGES),
    .LOAD_STAGES (LOAD_STAGES),
    .FWD_W       (FWD_W)
  ) u_match_b (
    .sb       (sb_q),
    .rs       (id_rs2),
    .used     (id_rs2_used),
    .load_hit (b_load),
    .fwd_sel  (b_sel)
  );

  // a held select follows its producer down the pipe until it reaches the RF
  function automatic logic [FWD_W-1:0] age_sel(
    input logic [FWD_W-1:0] s
  );
    if (s == FWD_W'(FWD_RF))
      return FWD_W'(FWD_RF);
    if (int'(s) + 1 > NSTAGES - 1)
      return FWD_W'(FWD_RF);
    return s + 1'b1;
  endfunction

  // hazard controls; redirect dominates load-use, busy freezes the front end
  always_comb begin
    id_e          = '0;
    id_e.valid    = 1'b1;
    id_e.rd       = id_rd;
    id_e.regwrite = id_regwrite;
    id_e.memread  = id_memread;
    load_use      = id_valid & (a_load | b_load);
    redir         = ex_redirect & ~ex_busy;
    stall_if      = ex_busy | (load_use & ~redir);
    stall_id      = stall_if;
    flush_if_id   = redir;
    bubble_ex     = ~ex_busy & (load_use | redir);
    issue         = id_valid & ~bubble_ex;
    for (int k = 0; k < NSTAGES; k++)
      stage_valid[k] = sb_q[k].valid;
  end

  // scoreboard shift and registered forward selects
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_q      <= '0;
      fwd_a_sel <= '0;
      fwd_b_sel <= '0;
    end else if (ex_busy) begin
      for (int k = 2; k < NSTAGES; k++)
        sb_q[k] <= sb_q[k-1];
      sb_q[1]   <= '0;
      fwd_a_sel <= age_sel(fwd_a_sel);
      fwd_b_sel <= age_sel(fwd_b_sel);
    end else begin
      for (int k = 1; k < NSTAGES; k++)
        sb_q[k] <= sb_q[k-1];
      sb_q[0]   <= issue ? id_e : '0;
      fwd_a_sel <= issue ? a_sel : FWD_W'(FWD_RF);
      fwd_b_sel <= issue ? b_sel : FWD_W'(FWD_RF);
    end
  end

endmodule
